// File: rtl/pattern_gen.sv
// Framed test-pattern source (inc/dec/PRBS/walking-one). First word one cycle after enable is sampled.
// Outputs are held while data_en=1 and ready=0. Pattern and burst counter advance only on data_en & ready.
module pattern_gen #(
  parameter int              DATA_W    = 8,
  parameter int              MAX_VAL   = 199,
  parameter int              BURST_LEN = 200,
  parameter int              GAP_LEN   = 0,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [DATA_W-1:0] LFSR_SEED = 8'h01
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              ready,
  output logic              data_en,
  output logic [DATA_W-1:0] data_in,
  output logic              data_last,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BURST_LEN - 1);
  localparam int                GAP_W    = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [DATA_W-1:0] MAX_W    = DATA_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  typedef enum logic [1:0] {M_INC = 2'b00, M_DEC = 2'b01, M_PRBS = 2'b10, M_WALK = 2'b11} pmode_t;

  state_t              state;
  state_t              state_nxt;
  pmode_t              mode_q;
  logic [DATA_W-1:0]   pat;
  logic [CNT_W-1:0]    burst_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                xfer;
  logic                burst_done;
  logic                gap_done;
  logic                load;

  function automatic logic [DATA_W-1:0] start_val(input pmode_t m);
    logic [DATA_W-1:0] r;
    case (m)
      M_INC:   r = '0;
      M_DEC:   r = MAX_W;
      M_PRBS:  r = LFSR_SEED;
      default: r = DATA_W'(1);
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] next_val(input pmode_t m, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    case (m)
      M_INC:   r = (v == MAX_W) ? '0 : v + DATA_W'(1);
      M_DEC:   r = (v == '0) ? MAX_W : v - DATA_W'(1);
      M_PRBS:  r = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
      default: r = {v[DATA_W-2:0], v[DATA_W-1]};
    endcase
    return r;
  endfunction

  assign xfer       = (state == RUN) && ready;
  assign burst_done = xfer && (burst_cnt == LAST_IDX);
  assign gap_done   = (state == GAP) && (gap_cnt == GAP_LAST);
  assign load       = (state == IDLE) && enable;

  always_ff @(posedge clk_50m) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        // enable is only consulted once the burst's final transfer has gone out
        if (burst_done) begin
          if (GAP_LEN > 0)  state_nxt = GAP;
          else if (!enable) state_nxt = IDLE;
        end
      end
      GAP:     if (gap_done) state_nxt = enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      mode_q    <= M_INC;
      pat       <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      // mode is latched only here, so the pattern continues across RUN->GAP->RUN
      if (load) begin
        mode_q <= pmode_t'(mode);
        pat    <= start_val(pmode_t'(mode));
      end else if (xfer) begin
        pat <= next_val(mode_q, pat);
      end
      if (burst_done) burst_cnt <= '0;
      else if (xfer)  burst_cnt <= burst_cnt + CNT_W'(1);
      if ((state == GAP) && !gap_done) gap_cnt <= gap_cnt + GAP_W'(1);
      else                             gap_cnt <= '0;
    end
  end

  assign data_en   = (state == RUN);
  assign data_in   = pat;
  assign data_last = data_en && (burst_cnt == LAST_IDX);

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: three configurations share one clock, checked cycle by cycle
// against a stream model that derives each word from its transfer index.
module tb_pattern_gen;
  logic clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic       rst;
  logic       enable;
  logic       ready;
  logic [1:0] mode;
  int         sel;
  int         total;
  int         bad;

  logic       en_a, en_b, en_c;
  logic       a_den, b_den, c_den, a_last, b_last, c_last, a_busy, b_busy, c_busy;
  logic [7:0] a_dat, b_dat, c_dat;
  logic       o_en, o_last, o_busy;
  logic [7:0] o_dat;

  assign en_a = enable && (sel == 0);
  assign en_b = enable && (sel == 1);
  assign en_c = enable && (sel == 2);

  pattern_gen u_a (.clk_50m(clk_50m), .rst(rst), .enable(en_a), .mode(mode), .ready(ready),
                   .data_en(a_den), .data_in(a_dat), .data_last(a_last), .busy(a_busy));
  pattern_gen #(.BURST_LEN(4), .GAP_LEN(2)) u_b (.clk_50m(clk_50m), .rst(rst), .enable(en_b),
                   .mode(mode), .ready(ready), .data_en(b_den), .data_in(b_dat),
                   .data_last(b_last), .busy(b_busy));
  pattern_gen #(.BURST_LEN(8), .GAP_LEN(0)) u_c (.clk_50m(clk_50m), .rst(rst), .enable(en_c),
                   .mode(mode), .ready(ready), .data_en(c_den), .data_in(c_dat),
                   .data_last(c_last), .busy(c_busy));

  always_comb begin
    o_en = a_den; o_dat = a_dat; o_last = a_last; o_busy = a_busy;
    if (sel == 1) begin
      o_en = b_den; o_dat = b_dat; o_last = b_last; o_busy = b_busy;
    end else if (sel == 2) begin
      o_en = c_den; o_dat = c_dat; o_last = c_last; o_busy = c_busy;
    end
  end

  // reference model: phase 0 idle, 1 streaming, 2 gap
  int         phase;
  int         k;
  int         nb;
  int         gleft;
  int         bl;
  int         gl;
  logic [1:0] m;
  bit         zero_chk;
  logic [7:0] got[$];

  logic [7:0] prbs_tab [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
  logic [7:0] walk_tab [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  function automatic logic [7:0] word(input logic [1:0] md, input int idx);
    logic [7:0] v;
    v = 8'h01;
    case (md)
      2'd0: v = 8'(idx % 200);
      2'd1: v = 8'(199 - (idx % 200));
      2'd2: for (int i = 0; i < idx; i++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
      default: v = 8'(1 << (idx % 8));
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (sel=%0d k=%0d)", tag, obs, exp, sel, k);
    end
  endtask

  task automatic tick();
    @(negedge clk_50m);
    chk("data_en", 32'(o_en), 32'(phase == 1));
    chk("busy", 32'(o_busy), 32'(phase != 0));
    if (phase == 1) begin
      chk("data_in", 32'(o_dat), 32'(word(m, k)));
      chk("data_last", 32'(o_last), 32'(nb == bl - 1));
    end else begin
      chk("last_idle", 32'(o_last), 0);
    end
    if (zero_chk) chk("rst_data", 32'(o_dat), 0);
    if (o_en && ready) got.push_back(o_dat);
    if (rst) begin
      phase = 0; zero_chk = 1'b1;
    end else begin
      case (phase)
        0: if (enable) begin
             phase = 1; k = 0; nb = 0; m = mode; zero_chk = 1'b0; got.delete();
           end
        1: if (ready) begin
             k++; nb++;
             if (nb == bl) begin
               nb = 0;
               if (gl > 0) begin phase = 2; gleft = gl; end
               else if (!enable) phase = 0;
             end
           end
        default: begin
          gleft--;
          if (gleft == 0) phase = enable ? 1 : 0;
        end
      endcase
    end
    @(posedge clk_50m); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic switch_to(input int s);
    sel = s; enable = 1'b0; ready = 1'b1; mode = 2'd0; rst = 1'b1;
    bl = (s == 0) ? 200 : (s == 1) ? 4 : 8;
    gl = (s == 1) ? 2 : 0;
    @(posedge clk_50m); #1;
    phase = 0; k = 0; nb = 0; zero_chk = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rnd(input int n, input bit allow_rst);
    for (int i = 0; i < n; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      rst = allow_rst && ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;

    // defaults, incrementing, continuous stream across bursts
    switch_to(0);
    enable = 1'b1;
    ticks(450);
    enable = 1'b0;
    ticks(210);

    // backpressure while data_in=5
    enable = 1'b1;
    ticks(6);
    ready = 1'b0;
    ticks(3);
    ready = 1'b1;
    ticks(4);
    chk("bp_seq6", 32'(got[5]), 32'd5);
    chk("bp_next", 32'(got[6]), 32'd6);

    // reset pulse mid-burst, restart at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(6);
    chk("rst_restart", 32'(got[0]), 0);
    rnd(150, 1'b0);

    // PRBS, with a mode change mid-burst that must be ignored
    switch_to(0);
    mode = 2'd2; enable = 1'b1;
    ticks(3);
    mode = 2'd0;
    ticks(20);
    for (int i = 0; i < 6; i++) chk("prbs_seq", 32'(got[i]), 32'(prbs_tab[i]));

    // walking-one
    switch_to(0);
    mode = 2'd3; enable = 1'b1;
    ticks(12);
    for (int i = 0; i < 9; i++) chk("walk_seq", 32'(got[i]), 32'(walk_tab[i]));

    // decrement with gaps
    switch_to(1);
    mode = 2'd1; enable = 1'b1;
    ticks(20);
    for (int i = 0; i < 8; i++) chk("dec_gap_seq", 32'(got[i]), 32'(199 - i));
    rnd(400, 1'b1);

    // enable dropped at transfer 2 of an 8-transfer burst
    switch_to(2);
    mode = 2'd0; enable = 1'b1;
    ticks(3);
    enable = 1'b0;
    ticks(12);
    chk("drop_count", 32'(got.size()), 32'd8);
    chk("drop_idle", 32'(o_busy), 0);
    mode = 2'd1; enable = 1'b1;
    ticks(10);
    chk("reenable_dec", 32'(got[0]), 32'd199);
    rnd(400, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised test-pattern source for the ping-pong buffer datapath. It is the successor to the fixed 0..199 free-running counter and adds configurable width and wrap value, four pattern modes, framed bursts with an inter-burst gap, and valid/ready backpressure. It drives the write side of the ping-pong buffer, or any stream sink, in the 50 MHz domain.

## Interface
Parameters:
- DATA_W, 8, data width in bits (>= 2)
- MAX_VAL, 199, wrap value for the counter modes; must be < 2^DATA_W
- BURST_LEN, 200, transfers per burst (>= 1)
- GAP_LEN, 0, idle cycles between bursts (0 = back-to-back)
- LFSR_TAPS, 8'hB8, Galois feedback mask for PRBS mode, DATA_W bits wide
- LFSR_SEED, 8'h01, PRBS start value; must be non-zero

Ports:
- clk_50m, in, 1: sole clock
- rst, in, 1: synchronous, active-high reset
- enable, in, 1: request bursts; level-sensitive
- mode, in, 2: 00 increment, 01 decrement, 10 PRBS, 11 walking-one
- ready, in, 1: sink can accept data this cycle
- data_en, out, 1: data_in/data_last valid
- data_in, out, DATA_W: pattern word
- data_last, out, 1: marks the final transfer of a burst
- busy, out, 1: high whenever the state is not IDLE

## Operation
- Transfer: occurs when data_en & ready are both high at a rising edge. While data_en=1 and ready=0, data_in and data_last hold stable.
- FSM states:
  - IDLE: data_en=0. Moves to RUN when enable=1.
  - RUN: data_en=1. After the BURST_LEN-th transfer, moves to GAP if GAP_LEN>0. Otherwise moves to RUN if enable=1, or to IDLE if enable=0.
  - GAP: data_en=0 for exactly GAP_LEN cycles. Then moves to RUN if enable=1, or to IDLE if enable=0.
- mode is sampled only on the IDLE->RUN transition. At that point the pattern register loads the start value:
  - increment: 0
  - decrement: MAX_VAL
  - PRBS: LFSR_SEED
  - walking-one: 1
- The pattern advances only on a transfer.
- Pattern continuity: the pattern continues across consecutive bursts (RUN->GAP->RUN or RUN->RUN). It reloads only on IDLE->RUN.
- Increment: MAX_VAL wraps to 0. Decrement: 0 wraps to MAX_VAL.
- PRBS: Galois LFSR, shifts right. If lsb=1, next = (v>>1) ^ LFSR_TAPS; otherwise next = v>>1. MAX_VAL is ignored.
- Walking-one: rotate left by 1 over DATA_W bits.
- Burst counter: width $clog2(BURST_LEN+1). It clears on entry to RUN and increments per transfer. data_last = data_en & (count == BURST_LEN-1).
- enable deasserted mid-burst: the current burst completes in full, including the last transfer. The block then goes to IDLE, via GAP if GAP_LEN>0.
- mode changed mid-burst or during GAP: ignored until the next IDLE->RUN transition.

## Timing
- Reset values (at the first edge with rst=1):
  - state: IDLE
  - data_en: 0
  - data_in: 0
  - data_last: 0
  - busy: 0
  - burst and gap counters: 0
- rst asserted mid-burst: the next edge forces the reset values regardless of ready or enable. No partial burst is resumed.
- Latency: enable rises and is sampled at edge N. At edge N, data_en=1 and data_in=start value; they are visible in cycle N+1.
- With ready held at 1: one new word per cycle. The burst occupies exactly BURST_LEN cycles of data_en=1.
- With GAP_LEN=0 and enable=1: data_en stays high continuously; data_last pulses for one transfer per burst.
- After the last transfer with GAP_LEN=G>0: data_en is low for exactly G cycles before the next burst's first word.
- busy is registered in step with state.

## Test plan
- Defaults, mode=00, ready=1, enable held high:
  - data_in = 0,1,...,199,0,1,...
  - data_last high on the word 199 of each 200-transfer burst.
  - data_en never drops.
- mode=01, BURST_LEN=4, GAP_LEN=2:
  - burst 1 = 199,198,197,196 with data_last on 196.
  - then 2 cycles of data_en=0.
  - burst 2 = 195,194,193,192.
- Backpressure, mode=00: drive ready=0 for 3 cycles while data_in=5.
  - data_in holds 5 with data_en=1 for those 3 cycles.
  - after ready returns to 1, the next word is 6; no value is skipped or duplicated.
- mode=10, defaults:
  - first words = 01,B8,5C,2E,17,B3.
  - mode=11, DATA_W=8: first words = 01,02,04,...,80,01.
- enable dropped at transfer 2 of a BURST_LEN=8 burst:
  - all 8 transfers complete, data_last on the 8th, then IDLE with busy=0.
  - re-enable with mode=01: the burst restarts at 199.
- rst pulsed for 1 cycle mid-burst with ready=1:
  - the next cycle shows data_en=0, data_in=0, busy=0.
  - with enable high, restart begins at 0 one cycle later.
